// File: rtl/assoc_cache_if.sv
// CPU byte port and memory line port bundle for assoc_cache.
// slave: the cache's view; master: the CPU/memory environment's view.
interface assoc_cache_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 16
);
  logic                    cpu_valid;
  logic                    cpu_wen;
  logic [ADDR_W-1:0]       cpu_addr;
  logic [7:0]              cpu_wdata;
  logic [7:0]              cpu_rdata;
  logic                    cpu_ready;
  logic                    mem_valid;
  logic                    mem_wen;
  logic [ADDR_W-1:0]       mem_addr;
  logic [LINE_BYTES*8-1:0] mem_wdata;
  logic [LINE_BYTES*8-1:0] mem_rdata;
  logic                    mem_ready;

  modport slave (
    input  cpu_valid, cpu_wen, cpu_addr, cpu_wdata,
    input  mem_rdata, mem_ready,
    output cpu_rdata, cpu_ready,
    output mem_valid, mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output cpu_valid, cpu_wen, cpu_addr, cpu_wdata,
    output mem_rdata, mem_ready,
    input  cpu_rdata, cpu_ready,
    input  mem_valid, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/assoc_cache.sv
// N-way set-associative write-back/write-allocate byte cache, round-robin victims.
// Optional hit/miss/writeback counters when ASSOC_CACHE_STATS_EN is defined.
module assoc_cache #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 16,
  parameter int SETS       = 8,
  parameter int WAYS       = 4
) (
  input  logic clk,
  input  logic rst_n,
  assoc_cache_if.slave bus
`ifdef ASSOC_CACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_wbacks
`endif
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    IDLE, COMPARE, WRITEBACK, ALLOCATE
  } state_t;

  state_t state, state_nx;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;
  logic              req_wen;
  logic [7:0]        req_wdata;

  logic [WAYS-1:0]   valid [SETS];
  logic [WAYS-1:0]   dirty [SETS];
  logic [WAY_W-1:0]  ptr   [SETS];
  logic [TAG_W-1:0]  tags  [SETS][WAYS];
  logic [LINE_W-1:0] lines [SETS][WAYS];

  logic [WAY_W-1:0]  vic, vic_nx, hit_way;
  logic              full, full_nx, hit;
  logic [LINE_W-1:0] hit_line;

  // Victim: lowest invalid way wins; otherwise the set's pointer.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_nx  = ptr[req_idx];
    full_nx = 1'b1;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid[req_idx][w] &&
          tags[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[req_idx][w]) begin
        vic_nx  = WAY_W'(w);
        full_nx = 1'b0;
      end
    end
  end

  assign hit_line = lines[req_idx][hit_way];

  always_comb begin
    state_nx      = state;
    bus.cpu_ready = 1'b0;
    bus.cpu_rdata = '0;
    bus.mem_valid = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (bus.cpu_valid) state_nx = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          bus.cpu_ready = 1'b1;
          if (!req_wen)
            bus.cpu_rdata = hit_line[{req_off, 3'b000} +: 8];
          state_nx = IDLE;
        end else if (valid[req_idx][vic_nx] &&
                     dirty[req_idx][vic_nx]) begin
          state_nx = WRITEBACK;
        end else begin
          state_nx = ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.mem_valid = 1'b1;
        bus.mem_wen   = 1'b1;
        bus.mem_addr  = {tags[req_idx][vic], req_idx,
                         {OFF_W{1'b0}}};
        bus.mem_wdata = lines[req_idx][vic];
        if (bus.mem_ready) state_nx = ALLOCATE;
      end
      ALLOCATE: begin
        bus.mem_valid = 1'b1;
        bus.mem_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (bus.mem_ready) state_nx = COMPARE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_tag   <= '0;
      req_idx   <= '0;
      req_off   <= '0;
      req_wen   <= 1'b0;
      req_wdata <= '0;
      vic       <= '0;
      full      <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        ptr[s]   <= '0;
      end
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (bus.cpu_valid) begin
            req_tag   <= bus.cpu_addr[ADDR_W-1 -: TAG_W];
            req_idx   <= bus.cpu_addr[OFF_W +: IDX_W];
            req_off   <= bus.cpu_addr[OFF_W-1:0];
            req_wen   <= bus.cpu_wen;
            req_wdata <= bus.cpu_wdata;
          end
        end
        COMPARE: begin
          if (hit) begin
            if (req_wen) dirty[req_idx][hit_way] <= 1'b1;
          end else begin
            vic  <= vic_nx;
            full <= full_nx;
          end
        end
        ALLOCATE: begin
          if (bus.mem_ready) begin
            valid[req_idx][vic] <= 1'b1;
            dirty[req_idx][vic] <= 1'b0;
            if (full)
              ptr[req_idx] <= (WAYS == 1) ? '0
                            : ptr[req_idx] + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Payload arrays carry no reset; valid bits gate them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == COMPARE && hit && req_wen)
        lines[req_idx][hit_way][{req_off, 3'b000} +: 8] <= req_wdata;
      if (state == ALLOCATE && bus.mem_ready) begin
        lines[req_idx][vic] <= bus.mem_rdata;
        tags[req_idx][vic]  <= req_tag;
      end
    end
  end

`ifdef ASSOC_CACHE_STATS_EN
  logic relook;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      relook      <= 1'b0;
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_wbacks <= '0;
    end else begin
      if (state == ALLOCATE && bus.mem_ready)
        relook <= 1'b1;
      else if (state == IDLE)
        relook <= 1'b0;
      if (state == COMPARE && !relook) begin
        if (hit) stat_hits   <= stat_hits + 1'b1;
        else     stat_misses <= stat_misses + 1'b1;
      end
      if (state == WRITEBACK && bus.mem_ready)
        stat_wbacks <= stat_wbacks + 1'b1;
    end
  end
`endif
endmodule

// File: doc/assoc_cache.md
# assoc_cache

Parametrised N-way set-associative, write-back, write-allocate cache between the CPU load/store port and the line-wide memory port. It generalises the team's fixed 4-way/8-set/128-bit cache types in ways, sets and line size, and adds round-robin victim selection, dirty-line writeback and an optional statistics block. The CPU side is byte-granular with a valid/ready handshake. The memory side moves whole lines with a valid/ready handshake.

## Interface
- `ADDR_W`, 32, address width.
- `LINE_BYTES`, 16, bytes per line; power of two, ≥4.
- `SETS`, 8, number of sets; power of two.
- `WAYS`, 4, associativity; power of two, 1–8.
- Derived values:
  - OFF_W = log2(LINE_BYTES)
  - IDX_W = log2(SETS)
  - TAG_W = ADDR_W−IDX_W−OFF_W (25 at defaults)
- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `cpu_valid`  in  1  request present.
- `cpu_wen`  in  1  1 = store byte, 0 = load byte.
- `cpu_addr`  in  ADDR_W  byte address.
- `cpu_wdata`  in  8  store byte.
- `cpu_rdata`  out  8  load byte; valid while `cpu_ready`.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `mem_valid`  out  1  memory request.
- `mem_wen`  out  1  1 = line writeback, 0 = line fill.
- `mem_addr`  out  ADDR_W  line-aligned address (low OFF_W bits zero).
- `mem_wdata`  out  LINE_BYTES*8  writeback line.
- `mem_rdata`  in  LINE_BYTES*8  fill line; sampled when `mem_ready`.
- `mem_ready`  in  1  memory completion.

## Operation
- Address split: offset = addr[OFF_W-1:0]; index = next IDX_W bits; tag = top TAG_W bits.
- Each entry holds valid, dirty, tag and line data. Each set has a WAYS-bit-log2 round-robin pointer.
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- **IDLE**
  - `cpu_valid`=1 latches addr, wen and wdata, then goes to COMPARE.
  - CPU inputs are ignored outside IDLE.
- **COMPARE**, hit (valid and tag match in any way):
  - Load: `cpu_rdata` = selected byte.
  - Store: writes the byte and sets dirty.
  - `cpu_ready`=1 this cycle, then goes to IDLE.
- **COMPARE**, miss; victim selection:
  - Victim = lowest-index invalid way.
  - If all ways are valid, victim = the way at the set's pointer.
  - If the victim is valid and dirty, go to WRITEBACK; otherwise go to ALLOCATE.
- **WRITEBACK**
  - Outputs: `mem_valid`=1, `mem_wen`=1, `mem_addr`={victim tag, index, 0}, `mem_wdata`=victim line.
  - Held until `mem_ready`, then goes to ALLOCATE.
- **ALLOCATE**
  - Outputs: `mem_valid`=1, `mem_wen`=0, `mem_addr`={req tag, index, 0}.
  - On `mem_ready`: write `mem_rdata` into the victim; valid=1, dirty=0, tag=req tag.
  - If all ways were valid, advance the set's pointer (mod WAYS).
  - Then go to COMPARE; the re-lookup hits and completes the request.
- The memory request stays asserted and stable every cycle until `mem_ready`, with no deassertion in between.
- Byte data in a line is little-endian: byte k occupies bits [8k+7:8k].

## Timing
- Reset (`rst_n`=0 at an edge):
  - FSM → IDLE.
  - All valid and dirty bits → 0; all pointers → 0.
  - `cpu_ready`, `mem_valid`, `mem_wen` → 0.
  - `mem_addr`, `mem_wdata`, `cpu_rdata` → 0.
- Reset mid-transaction abandons it. Dirty data is lost; memory sees `mem_valid` drop the next cycle.
- Hit latency: request accepted at edge k, `cpu_ready` high in cycle k+1. Throughput is one request per 2 cycles.
- Clean miss: 2 + F cycles, where F = cycles until `mem_ready` in ALLOCATE (≥1).
- Dirty miss: 2 + W + F cycles.
- `mem_ready` arriving in the first cycle of `mem_valid` is legal.
- `mem_ready` is ignored when `mem_valid`=0.
- `cpu_ready` is high for exactly one cycle per request.
- The CPU must deassert or change `cpu_valid` after `cpu_ready`. A still-high `cpu_valid` in the following IDLE cycle is a new request.

## Configuration
- Macro: `ASSOC_CACHE_STATS_EN`.
- Defined: adds outputs `stat_hits`, `stat_misses` and `stat_wbacks`, each 32 bits.
  - All three reset to 0.
  - Each increments on a first-COMPARE hit, first-COMPARE miss, and WRITEBACK completion respectively.
  - The re-lookup after ALLOCATE is not counted.
  - Counters wrap modulo 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- After reset, load 0x0000_0013 with memory returning line 0x0F0E…0100 → `mem_addr`=0x10, `cpu_rdata`=0x03, clean-miss latency 2+F.
- Store 0xAB to 0x15, then load 0x15 → both hit, `cpu_ready` in cycle k+1, `cpu_rdata`=0xAB, no `mem_valid`.
- Fill 5 distinct tags into set 1 (addresses 0x010, 0x090, 0x110, 0x190, 0x210) with a store to 0x010 first:
  - Fifth access triggers WRITEBACK of way 0: `mem_wen`=1, `mem_addr`=0x010.
  - Written line contains the stored byte.
- Continued misses in set 1 → victims rotate through ways 1, 2, 3, 0; clean victims produce no writeback.
- Hold `mem_ready` low 10 cycles during ALLOCATE, then assert `rst_n`=0 → `mem_valid` drops, FSM returns to IDLE, and a subsequent load of the same address misses again.
- With `ASSOC_CACHE_STATS_EN` defined, the scenarios above yield exact counts:
  - Hits counted only on the first COMPARE.
  - Wraparound checked by forcing `stat_hits`=0xFFFF_FFFF, then one hit → 0.
